// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : hazard_scoreboard
// Description : Tracks in-flight GPR writers past D, resolving stalls and
//               forwarding selects for D-stage operands, plus mult/div busy.
// Revision    : 1.0
// ============================================================================
module hazard_scoreboard #(
    parameter int DEPTH  = 3,
    parameter int NSRC   = 2,
    parameter int TW     = 2,
    parameter int MD_LAT = 5,
    parameter int SW     = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 issue_we,
    input  logic [4:0]           issue_dst,
    input  logic [TW-1:0]        issue_tnew,
    input  logic [NSRC-1:0]      src_used,
    input  logic [NSRC*5-1:0]    src_addr,
    input  logic [NSRC*TW-1:0]   src_tuse,
    input  logic                 d_is_md,
    input  logic                 md_start,
    output logic                 stall,
    output logic [NSRC*SW-1:0]   fwd_sel,
    output logic                 md_busy
);

    localparam int            c_cw       = $clog2(MD_LAT + 1);
    localparam logic [TW-1:0]   c_tnew_one = 1;
    localparam logic [c_cw-1:0] c_md_one   = 1;
    localparam logic [c_cw-1:0] c_md_lat   = c_cw'(MD_LAT);

    // Index i holds stage i+1 (0 = E).
    logic          r_valid [DEPTH];
    logic          r_we    [DEPTH];
    logic [4:0]    r_dst   [DEPTH];
    logic [TW-1:0] r_tnew  [DEPTH];

    logic [c_cw-1:0] r_md_cnt;
    logic [NSRC-1:0] w_src_haz;
    logic            w_stall;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_valid[i] <= 1'b0;
                r_we[i]    <= 1'b0;
                r_dst[i]   <= 5'd0;
                r_tnew[i]  <= '0;
            end
        end else begin
            r_valid[0] <= ~w_stall;
            r_we[0]    <= issue_we;
            r_dst[0]   <= issue_dst;
            r_tnew[0]  <= issue_tnew;
            for (int i = 1; i < DEPTH; i++) begin
                r_valid[i] <= r_valid[i-1];
                r_we[i]    <= r_we[i-1];
                r_dst[i]   <= r_dst[i-1];
                r_tnew[i]  <= (r_tnew[i-1] == '0) ? '0 : r_tnew[i-1] - c_tnew_one;
            end
        end
    end

    for (genvar s = 0; s < NSRC; s++) begin : g_src
        logic [4:0]    w_addr;
        logic [TW-1:0] w_tuse;
        logic          w_found;
        logic          w_haz;
        logic [SW-1:0] w_sel;

        assign w_addr = src_addr[5*s +: 5];
        assign w_tuse = src_tuse[TW*s +: TW];

        // Scan from the youngest stage; the first hit shadows older writers.
        always_comb begin
            w_found = 1'b0;
            w_haz   = 1'b0;
            w_sel   = '0;
            for (int i = 0; i < DEPTH; i++) begin
                if (!w_found && r_valid[i] && r_we[i] && (r_dst[i] == w_addr) &&
                    (r_dst[i] != 5'd0) && src_used[s]) begin
                    w_found = 1'b1;
                    if (r_tnew[i] == '0)
                        w_sel = SW'(i + 1);
                    w_haz = (r_tnew[i] > w_tuse);
                end
            end
        end

        assign fwd_sel[SW*s +: SW] = w_sel;
        assign w_src_haz[s]        = w_haz;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_md_cnt <= '0;
        else if (r_md_cnt != '0)
            r_md_cnt <= r_md_cnt - c_md_one;
        else if (md_start)
            r_md_cnt <= c_md_lat;
    end

    assign md_busy = (r_md_cnt != '0);
    assign w_stall = (|w_src_haz) | (d_is_md & (md_busy | md_start));
    assign stall   = w_stall;

endmodule
`default_nettype wire
